// File: rtl/riscv_rf_ctrl_pkg.sv
// Shared types and sizing helpers for the register-file writeback arbiter and scoreboard.
package riscv_rf_ctrl_pkg;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_LNG = 2'd2
    } req_e;

    // Round-robin pointer for write port B: names the source preferred on the next tie.
    typedef enum logic {
        RR_LSU = 1'b0,
        RR_LNG = 1'b1
    } rr_e;

    // Integer bank only when FPU = 0; both banks when the FP bank is present.
    function automatic int unsigned num_tot_words(input int unsigned addr_width, input bit fpu);
        return fpu ? (32'd1 << addr_width) : (32'd1 << (addr_width - 1));
    endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Reservation scoreboard: one busy bit per tracked register, set on issue, cleared on RF write.
module riscv_rf_scoreboard
    import riscv_rf_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int FPU        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid_i,
    input  logic [ADDR_WIDTH-1:0] iss_waddr_i,
    output logic                  iss_conflict_o,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  busy_c_o,
    input  logic                  clr_a_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_a_i,
    input  logic                  clr_b_i,
    input  logic [ADDR_WIDTH-1:0] clr_addr_b_i
);

    localparam int unsigned NUM_WORDS = num_tot_words(ADDR_WIDTH, FPU != 0);
    localparam int          IDX_W     = $clog2(NUM_WORDS);

    logic [NUM_WORDS-1:0] busy_q, busy_d;

    // r0 is hardwired, and FP addresses are untracked without an FP bank.
    function automatic logic tracked(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ((FPU != 0) || !a[ADDR_WIDTH-1]);
    endfunction

    function automatic logic lookup(input logic [NUM_WORDS-1:0] vec,
                                    input logic [ADDR_WIDTH-1:0] a);
        return tracked(a) && vec[a[IDX_W-1:0]];
    endfunction

    assign busy_a_o       = lookup(busy_q, raddr_a_i);
    assign busy_b_o       = lookup(busy_q, raddr_b_i);
    assign busy_c_o       = lookup(busy_q, raddr_c_i);
    assign iss_conflict_o = iss_valid_i && lookup(busy_q, iss_waddr_i);

    always_comb begin
        // NOTE: start from the held value so every path assigns busy_d and no latch is inferred.
        busy_d = busy_q;
        if (clr_a_i && tracked(clr_addr_a_i)) busy_d[clr_addr_a_i[IDX_W-1:0]] = 1'b0;
        if (clr_b_i && tracked(clr_addr_b_i)) busy_d[clr_addr_b_i[IDX_W-1:0]] = 1'b0;
        // Applied last so a same-edge set overrides a clear.
        if (iss_valid_i && !iss_conflict_o && tracked(iss_waddr_i))
            busy_d[iss_waddr_i[IDX_W-1:0]] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this vector is control state, not storage, so it must be reset to drop stale reservations.
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Writeback arbiter: merges ALU, LSU and long-op results onto two RF write ports with a
// registered output stage, and owns the reservation scoreboard used by ID-stage hazard logic.
module riscv_rf_wb_arbiter
    import riscv_rf_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_we_i,
    input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  lng_valid_i,
    output logic                  lng_ready_o,
    input  logic [ADDR_WIDTH-1:0] lng_waddr_i,
    input  logic [DATA_WIDTH-1:0] lng_wdata_i,
    input  logic                  iss_valid_i,
    input  logic [ADDR_WIDTH-1:0] iss_waddr_i,
    output logic                  iss_conflict_o,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  busy_c_o,
    output logic                  rf_we_a_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_a_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_a_o,
    output logic                  rf_we_b_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_b_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_b_o
);

    rr_e                   rr_q, rr_d;
    logic                  gnt_lsu, gnt_lng;
    req_e                  src_a, src_b;
    logic                  we_a_d, we_b_d, we_a_q, we_b_q;
    logic [ADDR_WIDTH-1:0] waddr_a_d, waddr_b_d, waddr_a_q, waddr_b_q;
    logic [DATA_WIDTH-1:0] wdata_a_d, wdata_b_d, wdata_a_q, wdata_b_q;

    // The ALU owns port A when active, leaving LSU and LNG to share port B.
    always_comb begin
        gnt_lsu = lsu_valid_i;
        gnt_lng = lng_valid_i;
        rr_d    = rr_q;
        if (alu_we_i && lsu_valid_i && lng_valid_i) begin
            gnt_lsu = (rr_q == RR_LSU);
            gnt_lng = (rr_q == RR_LNG);
            rr_d    = (rr_q == RR_LSU) ? RR_LNG : RR_LSU;
        end
    end

    assign lsu_ready_o = gnt_lsu && !rst;
    assign lng_ready_o = gnt_lng && !rst;

    always_comb begin
        src_a  = alu_we_i ? REQ_ALU : REQ_LSU;
        src_b  = (alu_we_i && gnt_lsu) ? REQ_LSU : REQ_LNG;
        we_a_d = alu_we_i || gnt_lsu;
        we_b_d = alu_we_i ? (gnt_lsu || gnt_lng) : gnt_lng;

        case (src_a)
            REQ_ALU: begin waddr_a_d = alu_waddr_i; wdata_a_d = alu_wdata_i; end
            default: begin waddr_a_d = lsu_waddr_i; wdata_a_d = lsu_wdata_i; end
        endcase

        case (src_b)
            REQ_LSU: begin waddr_b_d = lsu_waddr_i; wdata_b_d = lsu_wdata_i; end
            default: begin waddr_b_d = lng_waddr_i; wdata_b_d = lng_wdata_i; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= RR_LSU;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            waddr_a_q <= '0;
            waddr_b_q <= '0;
            wdata_a_q <= '0;
            wdata_b_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            rr_q      <= rr_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            waddr_a_q <= waddr_a_d;
            waddr_b_q <= waddr_b_d;
            wdata_a_q <= wdata_a_d;
            wdata_b_q <= wdata_b_d;
        end
    end

    assign rf_we_a_o    = we_a_q;
    assign rf_waddr_a_o = waddr_a_q;
    assign rf_wdata_a_o = wdata_a_q;
    assign rf_we_b_o    = we_b_q;
    assign rf_waddr_b_o = waddr_b_q;
    assign rf_wdata_b_o = wdata_b_q;

    // Reservations retire on the same edge the registered write lands in the RF.
    riscv_rf_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .FPU       (FPU)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .iss_valid_i   (iss_valid_i),
        .iss_waddr_i   (iss_waddr_i),
        .iss_conflict_o(iss_conflict_o),
        .raddr_a_i     (raddr_a_i),
        .raddr_b_i     (raddr_b_i),
        .raddr_c_i     (raddr_c_i),
        .busy_a_o      (busy_a_o),
        .busy_b_o      (busy_b_o),
        .busy_c_o      (busy_c_o),
        .clr_a_i       (we_a_q),
        .clr_addr_a_i  (waddr_a_q),
        .clr_b_i       (we_b_q),
        .clr_addr_b_i  (waddr_b_q)
    );

endmodule
